// File: rtl/trigger_gate_multi.sv
// trigger_gate_multi: NCH independent edge-triggered gate generators.
// Each channel synchronizes its trigger, detects the selected edge and then
// produces a gate of a latched duration after a latched delay, with an
// optional retrigger and a saturating accepted-event counter.
// Optional feature: define TRIG_HOLDOFF_EN to add a per-channel holdoff
// input and a HOLDOFF state entered after each gate.
module trigger_gate_multi #(
   parameter int NCH         = 4,
   parameter int DW          = 32,
   parameter int CW          = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    trigger,
   input  logic [NCH-1:0]    mask,
   input  logic [NCH-1:0]    edge_sel,
   input  logic [NCH-1:0]    retrig,
   input  logic [NCH*DW-1:0] delay,
   input  logic [NCH*DW-1:0] duration,
`ifdef TRIG_HOLDOFF_EN
   input  logic [NCH*DW-1:0] holdoff,
`endif
   input  logic              clr_cnt,
   output logic [NCH-1:0]    enable,
   output logic [NCH-1:0]    busy,
   output logic [NCH*CW-1:0] event_cnt
);

`ifdef TRIG_HOLDOFF_EN
   typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, HOLDOFF} state_t;
`else
   typedef enum logic [1:0] {IDLE, DELAY, ACTIVE} state_t;
`endif

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_r;
      logic                   prev_r;
      logic                   cur;
      logic                   edge_det;
      logic                   take_new;
      logic                   take_re;
      logic [DW-1:0]          dly_in;
      logic [DW-1:0]          dur_in;
      logic [DW-1:0]          cnt_r;
      logic [DW-1:0]          dur_lat_r;
      state_t                 state_r;
      logic                   en_r;
      logic [CW-1:0]          evt_r;
`ifdef TRIG_HOLDOFF_EN
      logic [DW-1:0]          hold_in;
      logic [DW-1:0]          hold_lat_r;
      assign hold_in = holdoff[i*DW +: DW];
`endif

      assign dly_in   = delay[i*DW +: DW];
      assign dur_in   = duration[i*DW +: DW];
      assign cur      = sync_r[SYNC_STAGES-1];
      assign edge_det = edge_sel[i] ? (prev_r & ~cur) : (~prev_r & cur);
      // A zero-length gate is never accepted, so it is never counted either.
      assign take_new = (state_r == IDLE) && edge_det && mask[i] && (dur_in != '0);
      assign take_re  = (state_r == ACTIVE) && edge_det && mask[i] && retrig[i] &&
                        (dur_in != '0);

      // Synchronizer chain and edge history; runs regardless of mask.
      always_ff @(posedge clk) begin
         if (rst) begin
            sync_r <= '0;
            prev_r <= 1'b0;
         end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], trigger[i]};
            prev_r <= cur;
         end
      end

      // Channel FSM: cnt_r counts remaining cycles of the current state.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_r <= IDLE;
            en_r    <= 1'b0;
            cnt_r   <= '0;
         end else if ((state_r != IDLE) && !mask[i]) begin
            state_r <= IDLE;
            en_r    <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (take_new) begin
                     dur_lat_r <= dur_in;
`ifdef TRIG_HOLDOFF_EN
                     hold_lat_r <= hold_in;
`endif
                     if (dly_in != '0) begin
                        state_r <= DELAY;
                        cnt_r   <= dly_in;
                     end else begin
                        state_r <= ACTIVE;
                        cnt_r   <= dur_in;
                        en_r    <= 1'b1;
                     end
                  end
               end
               DELAY: begin
                  if (cnt_r == DW'(1)) begin
                     state_r <= ACTIVE;
                     cnt_r   <= dur_lat_r;
                     en_r    <= 1'b1;
                  end else begin
                     cnt_r <= cnt_r - DW'(1);
                  end
               end
               ACTIVE: begin
                  if (take_re) begin
                     cnt_r     <= dur_in;
                     dur_lat_r <= dur_in;
                  end else if (cnt_r == DW'(1)) begin
                     en_r <= 1'b0;
`ifdef TRIG_HOLDOFF_EN
                     if (hold_lat_r != '0) begin
                        state_r <= HOLDOFF;
                        cnt_r   <= hold_lat_r;
                     end else begin
                        state_r <= IDLE;
                     end
`else
                     state_r <= IDLE;
`endif
                  end else begin
                     cnt_r <= cnt_r - DW'(1);
                  end
               end
`ifdef TRIG_HOLDOFF_EN
               HOLDOFF: begin
                  if (cnt_r == DW'(1)) state_r <= IDLE;
                  else                 cnt_r   <= cnt_r - DW'(1);
               end
`endif
               default: begin
                  state_r <= IDLE;
                  en_r    <= 1'b0;
               end
            endcase
         end
      end

      // Accepted-event counter; clear wins over a coincident accept.
      always_ff @(posedge clk) begin
         if (rst || clr_cnt)                          evt_r <= '0;
         else if ((take_new || take_re) && (evt_r != '1)) evt_r <= evt_r + CW'(1);
      end

      assign enable[i]            = en_r;
      assign busy[i]              = (state_r != IDLE);
      assign event_cnt[i*CW +: CW] = evt_r;
   end

endmodule

// File: tb/tb_trigger_gate_multi.sv
// Bench for trigger_gate_multi: directed scenarios plus randomized traffic,
// every cycle compared against an interval-based reference model.
// Define TRIG_HOLDOFF_EN to exercise the holdoff build.
module tb_trigger_gate_multi;
   localparam int NCH = 4;
   localparam int DW  = 8;
   localparam int CW  = 4;
   localparam int SS  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    trigger, mask, edge_sel, retrig;
   logic [NCH*DW-1:0] delay, duration;
`ifdef TRIG_HOLDOFF_EN
   logic [NCH*DW-1:0] holdoff;
`endif
   logic              clr_cnt;
   logic [NCH-1:0]    enable, busy;
   logic [NCH*CW-1:0] event_cnt;

   always #5 clk = ~clk;

   trigger_gate_multi #(.NCH(NCH), .DW(DW), .CW(CW), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst(rst), .trigger(trigger), .mask(mask), .edge_sel(edge_sel),
      .retrig(retrig), .delay(delay), .duration(duration),
`ifdef TRIG_HOLDOFF_EN
      .holdoff(holdoff),
`endif
      .clr_cnt(clr_cnt), .enable(enable), .busy(busy), .event_cnt(event_cnt));

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model: per channel, the synchronized view of the trigger and
   // the absolute cycle intervals of the gate [gs, ge] and busy period (.. bend].
   logic [SS-1:0] m_sync [NCH];
   logic          m_prev [NCH];
   int            gs [NCH];
   int            ge [NCH];
   int            bend [NCH];
   int            hlat [NCH];
   int            mcnt [NCH];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic void model_reset_all();
      for (int ch = 0; ch < NCH; ch++) begin
         m_sync[ch] = '0; m_prev[ch] = 1'b0;
         gs[ch] = -1; ge[ch] = -1; bend[ch] = -1; hlat[ch] = 0; mcnt[ch] = 0;
      end
   endfunction

   // Applies the inputs of cycle cyc; afterwards the model describes cycle cyc+1.
   function automatic void model_step();
      for (int ch = 0; ch < NCH; ch++) begin
         logic cur, ed, acc;
         int   d, l, h;
         cur = m_sync[ch][SS-1];
         ed  = edge_sel[ch] ? (m_prev[ch] && !cur) : (!m_prev[ch] && cur);
         d   = int'(delay[ch*DW +: DW]);
         l   = int'(duration[ch*DW +: DW]);
`ifdef TRIG_HOLDOFF_EN
         h   = int'(holdoff[ch*DW +: DW]);
`else
         h   = 0;
`endif
         acc = 1'b0;
         if (rst) begin
            gs[ch] = -1; ge[ch] = -1; bend[ch] = -1; mcnt[ch] = 0;
            m_sync[ch] = '0; m_prev[ch] = 1'b0;
         end else begin
            if (cyc <= bend[ch]) begin
               if (!mask[ch]) begin
                  bend[ch] = cyc; ge[ch] = cyc;
               end else if (cyc >= gs[ch] && cyc <= ge[ch] && ed && retrig[ch] && l != 0) begin
                  ge[ch] = cyc + l; bend[ch] = ge[ch] + hlat[ch]; acc = 1'b1;
               end
            end else if (ed && mask[ch] && l != 0) begin
               gs[ch] = cyc + d + 1; ge[ch] = cyc + d + l;
               hlat[ch] = h; bend[ch] = ge[ch] + h; acc = 1'b1;
            end
            if (clr_cnt) mcnt[ch] = 0;
            else if (acc && mcnt[ch] < (1 << CW) - 1) mcnt[ch]++;
            m_prev[ch] = cur;
            m_sync[ch] = {m_sync[ch][SS-2:0], trigger[ch]};
         end
      end
   endfunction

   task automatic tick();
      logic [NCH-1:0]    e_en, e_busy;
      logic [NCH*CW-1:0] e_cnt;
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      for (int ch = 0; ch < NCH; ch++) begin
         e_en[ch]            = (gs[ch] <= cyc) && (cyc <= ge[ch]);
         e_busy[ch]          = (cyc <= bend[ch]);
         e_cnt[ch*CW +: CW]  = CW'(mcnt[ch]);
      end
      chk("enable", 64'(enable), 64'(e_en));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("event_cnt", 64'(event_cnt), 64'(e_cnt));
   endtask

   task automatic meas(input int ch, input int n, output int first, output int width);
      first = -1; width = 0;
      for (int j = 0; j < n; j++) begin
         tick();
         if (enable[ch]) begin
            if (first < 0) first = cyc;
            width++;
         end
      end
   endtask

   task automatic clear_counters();
      clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
   endtask

   function automatic logic [CW-1:0] cnt_of(input int ch);
      return event_cnt[ch*CW +: CW];
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k, first, width, rises;
      logic pe;
      rst = 1'b1; trigger = '0; mask = '0; edge_sel = '0; retrig = '0;
      delay = '0; duration = '0; clr_cnt = 1'b0;
`ifdef TRIG_HOLDOFF_EN
      holdoff = '0;
`endif
      model_reset_all();
      tick(); tick();
      chk("rst_enable", 64'(enable), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_cnt", 64'(event_cnt), 64'(0));
      rst = 1'b0; mask = '1;
      repeat (4) tick();

      // ch0: rising, delay 0, duration 5
      delay[0*DW +: DW] = 8'd0; duration[0*DW +: DW] = 8'd5;
      k = cyc; trigger[0] = 1'b1;
      meas(0, 15, first, width);
      chk("c0_latency", 64'(first - k), 64'(SS + 1));
      chk("c0_width", 64'(width), 64'(5));
      chk("c0_count", 64'(cnt_of(0)), 64'(1));

      // ch1: falling-edge select, delay 3, duration 2
      edge_sel[1] = 1'b1; delay[1*DW +: DW] = 8'd3; duration[1*DW +: DW] = 8'd2;
      trigger[1] = 1'b1;
      meas(1, 12, first, width);
      chk("c1_rise_ignored", 64'(width), 64'(0));
      k = cyc; trigger[1] = 1'b0;
      meas(1, 15, first, width);
      chk("c1_latency", 64'(first - k), 64'(SS + 1 + 3));
      chk("c1_width", 64'(width), 64'(2));
      chk("c1_count", 64'(cnt_of(1)), 64'(1));

      // ch2: retrigger at gate cycle 6, then the same without retrigger
      delay[2*DW +: DW] = 8'd0; duration[2*DW +: DW] = 8'd10;
      for (int pass = 0; pass < 2; pass++) begin
         retrig[2] = (pass == 0);
         trigger[2] = 1'b0; repeat (4) tick();
         clear_counters();
         width = 0;
         for (int n = 0; n < 35; n++) begin
            if (n == 0) trigger[2] = 1'b1;
            if (n == 4) trigger[2] = 1'b0;
            if (n == 6) trigger[2] = 1'b1;
            tick();
            if (enable[2]) width++;
         end
         chk(pass == 0 ? "c2_retrig_width" : "c2_noretrig_width", 64'(width),
             64'(pass == 0 ? 16 : 10));
         chk(pass == 0 ? "c2_retrig_count" : "c2_noretrig_count", 64'(cnt_of(2)),
             64'(pass == 0 ? 2 : 1));
      end

      // ch3: mask drop at gate cycle 3 of 8, then re-arm with trigger held high
      delay[3*DW +: DW] = 8'd0; duration[3*DW +: DW] = 8'd8;
      width = 0;
      for (int n = 0; n < 20; n++) begin
         if (n == 0) trigger[3] = 1'b1;
         if (n == 5) mask[3] = 1'b0;
         tick();
         if (enable[3]) width++;
         if (n == 5) begin
            chk("c3_abort_enable", 64'(enable[3]), 64'(0));
            chk("c3_abort_busy", 64'(busy[3]), 64'(0));
         end
      end
      chk("c3_abort_width", 64'(width), 64'(3));
      mask[3] = 1'b1;
      meas(3, 15, first, width);
      chk("c3_rearm_no_pulse", 64'(width), 64'(0));

      // reset during DELAY on ch0
      trigger = '0; repeat (4) tick();
      delay[0*DW +: DW] = 8'd10; duration[0*DW +: DW] = 8'd3;
      width = 0;
      for (int n = 0; n < 25; n++) begin
         if (n == 0) trigger[0] = 1'b1;
         if (n == 5) begin rst = 1'b1; trigger[0] = 1'b0; end
         if (n == 6) rst = 1'b0;
         tick();
         if (enable[0]) width++;
      end
      chk("rst_mid_delay_width", 64'(width), 64'(0));
      chk("rst_mid_delay_cnt", 64'(event_cnt), 64'(0));

      // clr_cnt coincident with an accepted edge on ch1
      edge_sel[1] = 1'b0; delay[1*DW +: DW] = 8'd0; duration[1*DW +: DW] = 8'd2;
      width = 0;
      for (int n = 0; n < 10; n++) begin
         if (n == 0) trigger[1] = 1'b1;
         clr_cnt = (n == 2);
         tick();
         if (enable[1]) width++;
      end
      clr_cnt = 1'b0;
      chk("clr_coinc_width", 64'(width), 64'(2));
      chk("clr_coinc_cnt", 64'(cnt_of(1)), 64'(0));

      // duration 0 edge on ch0 is neither served nor counted
      delay[0*DW +: DW] = 8'd0; duration[0*DW +: DW] = 8'd0;
      trigger[0] = 1'b1;
      meas(0, 10, first, width);
      chk("dur0_width", 64'(width), 64'(0));
      chk("dur0_cnt", 64'(cnt_of(0)), 64'(0));

      // counter saturation on ch0: 20 accepted edges into a 4-bit counter
      duration[0*DW +: DW] = 8'd1;
      trigger[0] = 1'b0; repeat (4) tick();
      for (int n = 0; n < 40; n++) begin
         trigger[0] = ~trigger[0];
         repeat (3) tick();
      end
      repeat (4) tick();
      chk("sat_cnt", 64'(cnt_of(0)), 64'((1 << CW) - 1));

`ifdef TRIG_HOLDOFF_EN
      // ch0 duration 4, holdoff 6, rising edges every 5 cycles
      trigger = '0; retrig = '0; repeat (4) tick();
      delay[0*DW +: DW] = 8'd0; duration[0*DW +: DW] = 8'd4; holdoff[0*DW +: DW] = 8'd6;
      rises = 0; pe = enable[0];
      for (int n = 0; n < 45; n++) begin
         trigger[0] = ((n % 5) < 2) && (n < 40);
         tick();
         if (enable[0] && !pe && n <= 12) rises++;
         pe = enable[0];
      end
      chk("holdoff_second_edge_ignored", 64'(rises), 64'(1));
      holdoff = '0;
`endif

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            if ($urandom_range(0, 5) == 0) trigger[ch] = ~trigger[ch];
            if ($urandom_range(0, 39) == 0) mask[ch] = ~mask[ch];
            if ($urandom_range(0, 99) == 0) edge_sel[ch] = ~edge_sel[ch];
            if ($urandom_range(0, 49) == 0) retrig[ch] = ~retrig[ch];
            if ($urandom_range(0, 9) == 0) begin
               delay[ch*DW +: DW]    = DW'($urandom_range(0, 4));
               duration[ch*DW +: DW] = DW'($urandom_range(0, 7));
`ifdef TRIG_HOLDOFF_EN
               holdoff[ch*DW +: DW]  = DW'($urandom_range(0, 3));
`endif
            end
         end
         clr_cnt = ($urandom_range(0, 499) == 0);
         rst     = ($urandom_range(0, 1499) == 0);
         tick();
      end
      rst = 1'b0; clr_cnt = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
